ddram_loader: RTL and testbench
===============================

DDRAM_LOADER -- requirements
Module: ddram_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 4, word-FIFO entry count; power of two, minimum 2.
REQ-002 SHALL have parameter PAD, default 8'hFF, fill byte for the missing half of an incomplete word.
REQ-003 SHALL have port clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port ioctl_download  in  1  high for the duration of a byte download.
REQ-006 SHALL have port ioctl_addr  in  28  byte address of ioctl_dout.
REQ-007 SHALL have port ioctl_dout  in  8  download byte.
REQ-008 SHALL have port ioctl_wr  in  1  single-cycle byte strobe.
REQ-009 SHALL have port ioctl_wait  out  1  backpressure to the byte source.
REQ-010 SHALL have port wraddr  out  27  word address [27:1] to the DDR write port.
REQ-011 SHALL have port din  out  16  write word; low byte = even byte address.
REQ-012 SHALL have port we_req  out  1  toggle request to the DDR write port.
REQ-013 SHALL have port we_ack  in  1  toggle acknowledge from the DDR write port, same clock domain.
REQ-014 SHALL have port busy  out  1  work pending anywhere in the block.
REQ-015 SHALL have port overflow  out  1  sticky: a byte was lost.

Function
REQ-016 SHALL latch the byte on ioctl_wr with ioctl_addr[0]=0 as a pending low byte with word address ioctl_addr[27:1].
REQ-017 SHALL, on ioctl_wr with ioctl_addr[0]=1 and ioctl_addr[27:1] equal to the pending address, push {ioctl_dout, pending} and clear pending.
REQ-018 SHALL, on an odd byte with no matching pending byte, push {ioctl_dout, PAD} and leave any pending byte unchanged.
REQ-019 SHALL, on an even byte while a byte is already pending, push {PAD, old pending} and make the new byte pending.
REQ-020 SHALL push at most one word per cycle; every byte case above pushes exactly zero or one word.
REQ-021 SHALL register ioctl_wait high whenever FIFO count >= DEPTH-1 after the current cycle's push/pop.
REQ-022 SHALL drop an ioctl_wr byte that needs a push while the FIFO is full and set overflow, with no other state change.
REQ-023 SHALL implement the issue FSM states IDLE and WAIT.
REQ-024 SHALL, in IDLE with FIFO non-empty and we_req==we_ack, load wraddr/din from the FIFO head, pop, toggle we_req, and enter WAIT.
REQ-025 SHALL, in WAIT with we_ack==we_req, return to IDLE; a new issue can occur on the following cycle.
REQ-026 SHALL hold wraddr/din stable from the we_req toggle until the matching we_ack.
REQ-027 SHALL toggle we_req no earlier than 1 cycle after a word is pushed into an empty FIFO; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-028 SHALL, on ioctl_download falling edge with a byte pending, act per Configuration and then clear pending.
REQ-029 SHALL drive busy = ioctl_download | pending | FIFO non-empty | (state==WAIT).

Reset
REQ-030 SHALL, on reset assertion (asynchronous), force we_req=0, wraddr=0, din=0, ioctl_wait=0, overflow=0, pending cleared, FIFO empty, state=IDLE.
REQ-031 SHALL discard a word in flight when reset arrives mid-handshake; the system SHALL reset we_ack on the same reset.

Configuration
REQ-032 SHALL, with DDRAM_LOADER_TAIL_FLUSH_EN defined, push {PAD, pending} on the download falling edge (REQ-028); if the FIFO is full, the push SHALL stall until space frees, with busy held high.
REQ-033 SHALL, without DDRAM_LOADER_TAIL_FLUSH_EN, discard a trailing pending byte at download end; no word SHALL be written.

Verification
REQ-034 SHALL cover: bytes 0x11@0, 0x22@1 -> one write wraddr=0, din=16'h2211, one we_req toggle.
REQ-035 SHALL cover: 5 bytes 0x01..0x05 @0..4, then download low, with the macro defined -> writes 16'h0201@0, 16'h0403@1, 16'hFF05@2.
REQ-036 SHALL cover: same stimulus without the macro -> only the first two writes; busy falls after the last ack.
REQ-037 SHALL cover: we_ack held unchanged for 20 cycles while bytes stream, DEPTH=4 -> ioctl_wait high when 3 words are queued; no overflow when the source honours wait.
REQ-038 SHALL cover: byte 0xAA@7 with nothing pending -> din=16'hAAFF, wraddr=3.
REQ-039 SHALL cover: reset asserted during WAIT -> we_req=0, busy=0 with the download low, FIFO empty; next download writes correctly.

Source files
------------

// File: rtl/ddram_loader_if.sv
// DDR write-port bundle between the byte loader (master) and the DDR
// write port (slave): word address, write word and a toggle handshake.
interface ddram_loader_if;
   logic [26:0] wraddr;
   logic [15:0] din;
   logic        we_req;
   logic        we_ack;

   modport master (output wraddr, output din, output we_req, input we_ack);
   modport slave  (input wraddr, input din, input we_req, output we_ack);
endinterface

// File: rtl/ddram_loader.sv
// ddram_loader: packs an ioctl byte stream into 16-bit words, queues them in a
// small FIFO and issues them to a DDR write port with a toggle handshake.
// Optional feature macro DDRAM_LOADER_TAIL_FLUSH_EN: when defined, a trailing
// unpaired low byte is written padded at download end; otherwise it is dropped.
module ddram_loader #(
   parameter int unsigned DEPTH = 4,
   parameter logic [7:0]  PAD   = 8'hFF
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ioctl_download,
   input  logic [27:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   input  logic          ioctl_wr,
   output logic          ioctl_wait,
   ddram_loader_if.master ddr,
   output logic          busy,
   output logic          overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic {IDLE, WAIT} state_t;

   // FIFO entry: {word address, high byte, low byte}
   logic [42:0]   mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          pend_vld_q, pend_vld_d;
   logic [26:0]   pend_addr_q, pend_addr_d;
   logic [7:0]    pend_byte_q, pend_byte_d;

   logic          ovf_q, ovf_d;
   logic          wait_q, wait_d;
   logic          dl_q;
   logic          flush_q, flush_d;

   state_t        state_q;
   logic [26:0]   wraddr_q;
   logic [15:0]   din_q;
   logic          we_req_q;

   logic          full, pop, push, fall;
   logic [42:0]   push_word;

   assign full = (cnt_q == CW'(DEPTH));
   assign pop  = (state_q == IDLE) && (cnt_q != '0) && (we_req_q == ddr.we_ack);
   assign fall = dl_q & ~ioctl_download;

   // Byte pairing, overflow detection, tail handling and FIFO occupancy
   always_comb begin
      pend_vld_d  = pend_vld_q;
      pend_addr_d = pend_addr_q;
      pend_byte_d = pend_byte_q;
      ovf_d       = ovf_q;
      flush_d     = 1'b0;
      push        = 1'b0;
      push_word   = '0;

      if (ioctl_wr) begin
         if (!ioctl_addr[0]) begin
            if (pend_vld_q) begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  push        = 1'b1;
                  push_word   = {pend_addr_q, PAD, pend_byte_q};
                  pend_addr_d = ioctl_addr[27:1];
                  pend_byte_d = ioctl_dout;
               end
            end else begin
               pend_vld_d  = 1'b1;
               pend_addr_d = ioctl_addr[27:1];
               pend_byte_d = ioctl_dout;
            end
         end else if (pend_vld_q && (pend_addr_q == ioctl_addr[27:1])) begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               push       = 1'b1;
               push_word  = {ioctl_addr[27:1], ioctl_dout, pend_byte_q};
               pend_vld_d = 1'b0;
            end
         end else begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               push      = 1'b1;
               push_word = {ioctl_addr[27:1], ioctl_dout, PAD};
            end
         end
      end

`ifdef DDRAM_LOADER_TAIL_FLUSH_EN
      // A tail flush yields to a same-cycle byte push or a full FIFO and is
      // retried via flush_q while the byte stays pending (keeping busy high).
      if ((fall || flush_q) && pend_vld_q) begin
         if (!ioctl_wr && !full) begin
            push       = 1'b1;
            push_word  = {pend_addr_q, PAD, pend_byte_q};
            pend_vld_d = 1'b0;
         end else begin
            flush_d = 1'b1;
         end
      end
`else
      if (fall && pend_vld_q) begin
         pend_vld_d = 1'b0;
      end
`endif

      cnt_d  = cnt_q + CW'(push) - CW'(pop);
      wait_d = (cnt_d >= CW'(DEPTH - 1));
   end

   // FIFO storage write
   always_ff @(posedge clk_sys) begin
      if (push) begin
         mem_q[wp_q] <= push_word;
      end
   end

   // Pointers, pending byte and status registers
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wp_q        <= '0;
         rp_q        <= '0;
         cnt_q       <= '0;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         pend_byte_q <= '0;
         ovf_q       <= 1'b0;
         wait_q      <= 1'b0;
         dl_q        <= 1'b0;
         flush_q     <= 1'b0;
      end else begin
         if (push) wp_q <= wp_q + AW'(1);
         if (pop)  rp_q <= rp_q + AW'(1);
         cnt_q       <= cnt_d;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         pend_byte_q <= pend_byte_d;
         ovf_q       <= ovf_d;
         wait_q      <= wait_d;
         dl_q        <= ioctl_download;
         flush_q     <= flush_d;
      end
   end

   // Issue FSM: hand the FIFO head to the DDR port and wait for the ack toggle
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         wraddr_q <= '0;
         din_q    <= '0;
         we_req_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  {wraddr_q, din_q} <= mem_q[rp_q];
                  we_req_q          <= ~we_req_q;
                  state_q           <= WAIT;
               end
            end
            WAIT: begin
               if (ddr.we_ack == we_req_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ddr.wraddr = wraddr_q;
   assign ddr.din    = din_q;
   assign ddr.we_req = we_req_q;
   assign ioctl_wait = wait_q;
   assign overflow   = ovf_q;
   assign busy       = ioctl_download | pend_vld_q | (cnt_q != '0) | (state_q == WAIT);

endmodule

// File: tb/tb_ddram_loader.sv
// Self-checking bench for ddram_loader: randomized byte streams and DDR ack
// delays checked against a byte-level reference model of the packing rules.
module tb_ddram_loader;

   localparam logic [7:0] PAD = 8'hFF;

   logic        clk;
   logic        reset;
   logic        ioctl_download;
   logic [27:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wr;
   logic        ioctl_wait;
   logic        busy;
   logic        overflow;

   ddram_loader_if bus ();

   ddram_loader #(.DEPTH(4), .PAD(8'hFF)) dut (
      .clk_sys        (clk),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wr       (ioctl_wr),
      .ioctl_wait     (ioctl_wait),
      .ddr            (bus),
      .busy           (busy),
      .overflow       (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: expected DDR writes as {addr[26:0], din[15:0]}
   logic [42:0] exp_q[$];
   logic [42:0] got_q[$];
   int unsigned got_base = 0;
   bit          m_pv = 0;
   logic [26:0] m_pa;
   logic [7:0]  m_pb;

   task automatic model_byte(input logic [27:0] a, input logic [7:0] d);
      logic [26:0] wa;
      wa = a[27:1];
      if (!a[0]) begin
         if (m_pv) exp_q.push_back({m_pa, PAD, m_pb});
         m_pv = 1; m_pa = wa; m_pb = d;
      end else if (m_pv && m_pa == wa) begin
         exp_q.push_back({wa, d, m_pb});
         m_pv = 0;
      end else begin
         exp_q.push_back({wa, d, PAD});
      end
   endtask

   task automatic model_fall();
`ifdef DDRAM_LOADER_TAIL_FLUSH_EN
      if (m_pv) exp_q.push_back({m_pa, PAD, m_pb});
`endif
      m_pv = 0;
   endtask

   // DDR write-port responder: random ack delay, optional hold, reset-aware
   bit          hold = 0;
   int unsigned ntog = 0;
   initial begin
      bit          inflight;
      int unsigned dly;
      logic [42:0] cap;
      inflight = 0;
      dly = 0;
      cap = '0;
      bus.we_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (reset) begin
            bus.we_ack = 1'b0;
            inflight = 0;
         end else if (!hold && bus.we_req != bus.we_ack) begin
            if (!inflight) begin
               inflight = 1;
               cap = {bus.wraddr, bus.din};
               dly = $urandom_range(0, 3);
               ntog++;
            end else if (dly != 0) begin
               dly--;
            end else begin
               check("hold_addr", bus.wraddr, cap[42:16]);
               check("hold_din", bus.din, cap[15:0]);
               got_q.push_back(cap);
               bus.we_ack = ~bus.we_ack;
               inflight = 0;
            end
         end
      end
   end

   task automatic cyc(input int unsigned n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_raw(input logic [27:0] a, input logic [7:0] d);
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic send_byte(input logic [27:0] a, input logic [7:0] d);
      int unsigned n;
      n = 0;
      while (ioctl_wait && n < 300) begin cyc(1); n++; end
      if (ioctl_wait) check("wait_timeout", ioctl_wait, 1'b0);
      model_byte(a, d);
      send_raw(a, d);
   endtask

   task automatic drain();
      int unsigned n;
      ioctl_download = 1'b0;
      model_fall();
      n = 0;
      while (busy && n < 500) begin cyc(1); n++; end
      check("drain_busy", busy, 1'b0);
   endtask

   task automatic compare_writes();
      int unsigned ng;
      ng = got_q.size() - got_base;
      check("n_writes", ng, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < ng; i++) begin
         check("wr_addr", got_q[got_base+i][42:16], exp_q[i][42:16]);
         check("wr_din", got_q[got_base+i][15:0], exp_q[i][15:0]);
      end
      got_base = got_q.size();
      exp_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t0;
      logic [27:0] a;
      reset = 1'b1;
      ioctl_download = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      ioctl_wr = 1'b0;
      cyc(3);
      check("rst_we_req", bus.we_req, 1'b0);
      check("rst_wraddr", bus.wraddr, 27'd0);
      check("rst_din", bus.din, 16'd0);
      check("rst_wait", ioctl_wait, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;
      cyc(2);

      // two bytes form one word
      t0 = ntog;
      ioctl_download = 1'b1;
      send_byte(28'd0, 8'h11);
      send_byte(28'd1, 8'h22);
      drain();
      check("t34_toggles", ntog - t0, 1);
      if (got_q.size() > got_base) check("t34_word", got_q[got_base], {27'd0, 16'h2211});
      compare_writes();

      // five bytes then download end: tail word depends on the build option
      ioctl_download = 1'b1;
      for (int i = 0; i < 5; i++) send_byte(28'(i), 8'(i + 1));
      drain();
`ifdef DDRAM_LOADER_TAIL_FLUSH_EN
      check("t35_n", got_q.size() - got_base, 3);
`else
      check("t36_n", got_q.size() - got_base, 2);
`endif
      if (got_q.size() > got_base + 1) begin
         check("t35_w0", got_q[got_base], {27'd0, 16'h0201});
         check("t35_w1", got_q[got_base+1], {27'd1, 16'h0403});
      end
`ifdef DDRAM_LOADER_TAIL_FLUSH_EN
      if (got_q.size() > got_base + 2) check("t35_w2", got_q[got_base+2], {27'd2, 16'hFF05});
`endif
      compare_writes();

      // lone odd byte is padded low
      ioctl_download = 1'b1;
      send_byte(28'd7, 8'hAA);
      drain();
      if (got_q.size() > got_base) check("t38_word", got_q[got_base], {27'd3, 16'hAAFF});
      compare_writes();

      // ack withheld: wait rises with three words queued, no loss
      hold = 1;
      ioctl_download = 1'b1;
      for (int i = 0; i < 8; i++) send_byte(28'(i), 8'h30 + 8'(i));
      cyc(1);
      check("t37_wait", ioctl_wait, 1'b1);
      check("t37_req_open", bus.we_req ^ bus.we_ack, 1'b1);
      cyc(18);
      check("t37_wait_held", ioctl_wait, 1'b1);
      check("t37_no_write", got_q.size() - got_base, 0);
      hold = 0;
      for (int i = 8; i < 16; i++) send_byte(28'(i), 8'h30 + 8'(i));
      drain();
      check("t37_ovf", overflow, 1'b0);
      compare_writes();

      // randomized streams with gaps, unpaired bytes and random ack delays
      for (int r = 0; r < 4; r++) begin
         ioctl_download = 1'b1;
         a = 28'(32'h100 * (r + 1) + $urandom_range(0, 3));
         for (int i = 0; i < 24; i++) begin
            send_byte(a, 8'($urandom));
            cyc($urandom_range(0, 2));
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4, 5: a = a + 28'd1;
               6, 7:             a = a + 28'($urandom_range(2, 3));
               default:          a = a + 28'($urandom_range(0, 8));
            endcase
         end
         drain();
         compare_writes();
      end
      check("rand_ovf", overflow, 1'b0);

      // source ignores wait while ack is withheld: one in flight + 4 queued
      hold = 1;
      ioctl_download = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (i < 5) model_byte(28'(2 * i + 1), 8'h50 + 8'(i));
         send_raw(28'(2 * i + 1), 8'h50 + 8'(i));
         cyc(1);
      end
      check("ovf_set", overflow, 1'b1);
      hold = 0;
      drain();
      check("ovf_sticky", overflow, 1'b1);
      compare_writes();

      // reset in the middle of a handshake
      hold = 1;
      ioctl_download = 1'b1;
      send_byte(28'd0, 8'h33);
      send_byte(28'd1, 8'h44);
      cyc(3);
      check("t39_in_wait", bus.we_req ^ bus.we_ack, 1'b1);
      check("t39_busy_pre", busy, 1'b1);
      ioctl_download = 1'b0;
      reset = 1'b1;
      cyc(1);
      check("t39_we_req", bus.we_req, 1'b0);
      check("t39_busy", busy, 1'b0);
      check("t39_wait", ioctl_wait, 1'b0);
      check("t39_ovf", overflow, 1'b0);
      cyc(2);
      hold = 0;
      exp_q.delete();
      m_pv = 0;
      got_base = got_q.size();
      reset = 1'b0;
      cyc(2);
      check("t39_ack_low", bus.we_ack, 1'b0);
      ioctl_download = 1'b1;
      send_byte(28'd10, 8'h55);
      send_byte(28'd11, 8'h66);
      drain();
      if (got_q.size() > got_base) check("t39_word", got_q[got_base], {27'd5, 16'h6655});
      compare_writes();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
